// File: rtl/scan_pkg.sv
// Shared definitions for the decoder scan sequencer: state encoding, mode and
// start-select constants, the registered decoder-drive bundle and a sel step helper.
// Contents: state_t, MODE_*, SEL_FIRST_*, dec_out_t, DEC_IDLE, sel_step().
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BLINK = 2'd2
  } state_t;

  localparam logic MODE_SCAN  = 1'b0;
  localparam logic MODE_BLINK = 1'b1;

  localparam logic [2:0] SEL_FIRST_UP = 3'd0;
  localparam logic [2:0] SEL_FIRST_DN = 3'd7;

  // Everything the sequencer drives, kept as one registered bundle.
  typedef struct packed {
    logic       en;
    logic       sel_a;
    logic       sel_b;
    logic [2:0] sel;
    logic       busy;
    logic       wrap;
  } dec_out_t;

  localparam dec_out_t DEC_IDLE = '0;

  // One scan step, modulo 8 in either direction.
  function automatic logic [2:0] sel_step(input logic [2:0] s, input logic down);
    return down ? (s - 3'd1) : (s + 3'd1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Step-pacing prescaler: tick is high for one cycle out of every TICK_DIV.
// Latency: tick is combinational from the count register; first tick TICK_DIV cycles after clr drops.
// Backpressure: none; clr holds the count at 0.
// Ports: clk, rst (async, active-high), clr (sync clear), tick (count == TICK_DIV-1).
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/scan_sequencer.sv
// Drives the 3-to-8 decoder (E/A/B/S): walking-one scan sweeps or a timed blink of its fixed pattern.
// Latency: all outputs registered; a run starts the cycle after start, each step lasts TICK_DIV cycles.
// Backpressure: none; start is ignored while busy, stop aborts to idle on the next cycle.
// Ports: clk, rst | start, stop, mode_sel, dir | en, sel_a, sel_b, sel[2:0], busy, wrap.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int PASSES   = 2,
  parameter int BLINKS   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       mode_sel,
  input  logic       dir,
  output logic       en,
  output logic       sel_a,
  output logic       sel_b,
  output logic [2:0] sel,
  output logic       busy,
  output logic       wrap
);

  // PASSES == 0 means endless scanning; the counter is then kept at one bit and never moves.
  localparam int PW = (PASSES == 0) ? 1 : $clog2(PASSES + 1);
  localparam int BW = $clog2(BLINKS + 1);
  localparam logic [PW-1:0] PASS_LAST  = (PASSES == 0) ? '0 : PW'(PASSES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINKS - 1);

  state_t        state_q, state_d;
  dec_out_t      out_q, out_d;
  logic          dir_q, dir_d;
  logic [PW-1:0] pass_q, pass_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          tick;
  logic          psc_clr;
  logic [2:0]    sel_nxt;

  // Holding the prescaler clear throughout IDLE means it is at 0 on every entry
  // to SCAN or BLINK, so the first step lands TICK_DIV cycles after entry.
  assign psc_clr = (state_q == ST_IDLE) || stop;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_psc (
    .clk (clk),
    .rst (rst),
    .clr (psc_clr),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= DEC_IDLE;
      dir_q   <= 1'b0;
      pass_q  <= '0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      pass_q  <= pass_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    out_d.wrap = 1'b0;
    dir_d      = dir_q;
    pass_d     = pass_q;
    blink_d    = blink_q;
    sel_nxt    = sel_step(out_q.sel, dir_q);

    unique case (state_q)
      ST_IDLE: begin
        out_d   = DEC_IDLE;
        pass_d  = '0;
        blink_d = '0;
        if (start && !stop) begin
          dir_d      = dir;
          out_d.en   = 1'b1;
          out_d.busy = 1'b1;
          if (mode_sel == MODE_BLINK) begin
            state_d     = ST_BLINK;
            out_d.sel_b = 1'b1;
          end else begin
            state_d     = ST_SCAN;
            out_d.sel_a = 1'b1;
            out_d.sel   = dir ? SEL_FIRST_DN : SEL_FIRST_UP;
          end
        end
      end

      ST_SCAN: begin
        if (tick) begin
          out_d.sel = sel_nxt;
          // Stepping back onto the first select value closes a sweep.
          if (sel_nxt == (dir_q ? SEL_FIRST_DN : SEL_FIRST_UP)) begin
            out_d.wrap = 1'b1;
            if (PASSES != 0) begin
              if (pass_q == PASS_LAST) begin
                state_d    = ST_IDLE;
                out_d      = DEC_IDLE;
                out_d.wrap = 1'b1;
                pass_d     = '0;
              end else begin
                pass_d = pass_q + PW'(1);
              end
            end
          end
        end
      end

      ST_BLINK: begin
        if (tick) begin
          out_d.sel_b = ~out_q.sel_b;
          // Each pattern-on period ends on the 1->0 toggle.
          if (out_q.sel_b) begin
            out_d.wrap = 1'b1;
            if (blink_q == BLINK_LAST) begin
              state_d    = ST_IDLE;
              out_d      = DEC_IDLE;
              out_d.wrap = 1'b1;
              blink_d    = '0;
            end else begin
              blink_d = blink_q + BW'(1);
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        out_d   = DEC_IDLE;
        pass_d  = '0;
        blink_d = '0;
      end
    endcase

    // Abort overrides everything, including a run's final wrap.
    if (stop) begin
      state_d = ST_IDLE;
      out_d   = DEC_IDLE;
      pass_d  = '0;
      blink_d = '0;
    end
  end

  assign en    = out_q.en;
  assign sel_a = out_q.sel_a;
  assign sel_b = out_q.sel_b;
  assign sel   = out_q.sel;
  assign busy  = out_q.busy;
  assign wrap  = out_q.wrap;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer with TICK_DIV=4, PASSES=1, BLINKS=2.
// Expected per-cycle output traces are built from the step/period rules and compared every cycle.
module tb_scan_sequencer;

  localparam int TD = 4;
  localparam int NP = 1;
  localparam int NB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode_sel = 1'b0;
  logic       dir = 1'b0;
  logic       en, sel_a, sel_b, busy, wrap;
  logic [2:0] sel;

  int checks = 0;
  int errors = 0;

  // Observation word: {en, sel_a, sel_b, sel[2:0], busy, wrap}
  logic [7:0] exp_q[$];

  scan_sequencer #(
    .TICK_DIV(TD),
    .PASSES  (NP),
    .BLINKS  (NB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .mode_sel(mode_sel),
    .dir     (dir),
    .en      (en),
    .sel_a   (sel_a),
    .sel_b   (sel_b),
    .sel     (sel),
    .busy    (busy),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pk(input logic e, input logic a, input logic b,
                                    input logic [2:0] s, input logic bz, input logic w);
    return {e, a, b, s, bz, w};
  endfunction

  task automatic check(input string tag, input logic [7:0] ex);
    logic [7:0] ob;
    ob = {en, sel_a, sel_b, sel, busy, wrap};
    checks++;
    assert (ob === ex) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, ob, ex);
    end
  endtask

  // Expected outputs for each cycle of a full run, starting the cycle after start is taken.
  task automatic build(input logic m, input logic d);
    logic [2:0] s;
    exp_q.delete();
    if (m == 1'b0) begin
      for (int p = 0; p < NP; p++)
        for (int k = 0; k < 8; k++) begin
          s = d ? 3'(7 - k) : 3'(k);
          for (int c = 0; c < TD; c++)
            exp_q.push_back(pk(1, 1, 0, s, 1, (c == 0 && k == 0 && p > 0)));
        end
    end else begin
      for (int b = 0; b < NB; b++) begin
        for (int c = 0; c < TD; c++) exp_q.push_back(pk(1, 0, 1, 3'd0, 1, 0));
        if (b < NB - 1)
          for (int c = 0; c < TD; c++) exp_q.push_back(pk(1, 0, 0, 3'd0, 1, (c == 0)));
      end
    end
    // The closing sweep/on-period pulses wrap as the block lands in idle.
    exp_q.push_back(pk(0, 0, 0, 3'd0, 0, 1));
  endtask

  // Start a run, check every cycle; optionally stop at trace index stop_at and add noise on
  // mode_sel/dir/start while busy.
  task automatic run(input logic m, input logic d, input int stop_at, input bit noise,
                     input string tag);
    build(m, d);
    @(negedge clk);
    start = 1'b1; mode_sel = m; dir = d;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      check(tag, exp_q[i]);
      if (noise) begin
        mode_sel = 1'($urandom);
        dir      = 1'($urandom);
        if (i < exp_q.size() - 1) start = ($urandom_range(0, 3) == 0);
      end
      if (i == stop_at) begin
        stop = 1'b1;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check({tag, "_idle"}, 8'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset", 8'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 8'd0);

    run(1'b0, 1'b0, -1, 1'b0, "scan_up");
    run(1'b0, 1'b1, -1, 1'b0, "scan_down");
    run(1'b1, 1'b0, -1, 1'b0, "blink");
    run(1'b0, 1'b0, 5 * TD + 1, 1'b0, "stop_sel5");
    run(1'b1, 1'b1, TD + 2, 1'b0, "stop_blink");

    // start and stop together in idle: stop wins
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("start_stop_idle", 8'd0);
      @(negedge clk);
    end

    // noisy start/mode_sel/dir while busy must not disturb the run
    run(1'b0, 1'b1, -1, 1'b1, "noise_scan");
    run(1'b1, 1'b0, -1, 1'b1, "noise_blink");

    // asynchronous reset mid-scan at sel=3
    build(1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; mode_sel = 1'b0; dir = 1'b0;
    for (int i = 0; i < 3 * TD + 2; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("pre_rst", exp_q[i]);
    end
    #2 rst = 1'b1;
    #1 check("rst_async", 8'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", 8'd0);
    end

    // randomized runs, some aborted
    for (int r = 0; r < 8; r++) begin
      logic rm, rd;
      int   sa;
      rm = 1'($urandom);
      rd = 1'($urandom);
      sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1;
      run(rm, rd, sa, 1'b1, "rand_run");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
